// File: rtl/bcd_to_bin_decoder.sv
// Iterative 9-digit packed BCD to 30-bit binary decoder (reverse double-dabble).
// Ports: clk, reset (async low), start, bcd_in -> busy, done, bin_out, err.
module bcd_to_bin_decoder #(
  parameter int DIGITS = 9,
  parameter int BIN_W  = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t          state;
  logic [BW-1:0]   bcd_work;
  logic [BIN_W-1:0] bin_work;
  logic [CW-1:0]   cnt;
  logic            invalid;

  logic [BW-1:0]    sh_bcd;
  logic [BIN_W-1:0] sh_bin;
  logic [BW-1:0]    nxt_bcd;
  logic             bad_in;

  // One iteration: shift the pair right, then pull any digit
  // that reached 8..15 back down by 3 (undoes the add-3 step).
  always_comb begin
    sh_bcd  = {1'b0, bcd_work[BW-1:1]};
    sh_bin  = {bcd_work[0], bin_work[BIN_W-1:1]};
    nxt_bcd = sh_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (sh_bcd[4*i+3])
        nxt_bcd[4*i +: 4] = sh_bcd[4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9)
        bad_in = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bcd_work <= '0;
      bin_work <= '0;
      cnt      <= '0;
      invalid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bin_out  <= '0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= CONV;
            bcd_work <= bcd_in;
            bin_work <= '0;
            cnt      <= CW'(BIN_W);
            invalid  <= bad_in;
            busy     <= 1'b1;
          end
        end
        CONV: begin
          bcd_work <= nxt_bcd;
          bin_work <= sh_bin;
          cnt      <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            err     <= invalid;
            bin_out <= invalid ? '0 : sh_bin;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
